serial_subtractor: RTL

- Bit-serial, multi-cycle subtractor that computes Diff = A - B one bit per cycle, LSB first, using a borrow register.
- It is the inverse-operation companion to the team's registered parallel adder and shares its clock-enable convention.
- A Start/Busy/Done handshake is used by the datapath sequencer to run subtraction while spending little area.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, one bit per enabled cycle, LSB first.
// Optional macro SUB_SIGNED_OVF_EN adds a registered two's-complement Overflow output.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             Overflow
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0] sa_n, sb_n, sr_n, diff_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             br, br_n, borrow_n, done_n;
    logic             d, br_out;
    logic [WIDTH-1:0] sr_shift;

`ifdef SUB_SIGNED_OVF_EN
    logic a_msb, b_msb, a_msb_n, b_msb_n, ovf_n;
`endif

    // One full-subtractor slice on the current LSBs.
    assign d        = sa[0] ^ sb[0] ^ br;
    assign br_out   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign sr_shift = {d, sr[WIDTH-1:1]};
    assign Busy     = (state == RUN);

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        sa_n     = sa;
        sb_n     = sb;
        sr_n     = sr;
        br_n     = br;
        cnt_n    = cnt;
        diff_n   = Diff;
        borrow_n = Borrow;
        done_n   = Done;
`ifdef SUB_SIGNED_OVF_EN
        a_msb_n  = a_msb;
        b_msb_n  = b_msb;
        ovf_n    = Overflow;
`endif
        if (En) begin
            done_n = 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        sa_n    = A;
                        sb_n    = B;
                        br_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RUN;
`ifdef SUB_SIGNED_OVF_EN
                        a_msb_n = A[WIDTH-1];
                        b_msb_n = B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa_n  = {1'b0, sa[WIDTH-1:1]};
                    sb_n  = {1'b0, sb[WIDTH-1:1]};
                    sr_n  = sr_shift;
                    br_n  = br_out;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_n   = sr_shift;
                        borrow_n = br_out;
                        done_n   = 1'b1;
                        cnt_n    = '0;
                        state_n  = IDLE;
`ifdef SUB_SIGNED_OVF_EN
                        ovf_n    = (a_msb != b_msb) && (sr_shift[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            Done     <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Overflow <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            sa       <= sa_n;
            sb       <= sb_n;
            sr       <= sr_n;
            br       <= br_n;
            cnt      <= cnt_n;
            Diff     <= diff_n;
            Borrow   <= borrow_n;
            Done     <= done_n;
`ifdef SUB_SIGNED_OVF_EN
            a_msb    <= a_msb_n;
            b_msb    <= b_msb_n;
            Overflow <= ovf_n;
`endif
        end
    end

endmodule
